// File: rtl/select_scanner.sv
// Captures a source word and streams in_len+1 of its bits, one per output
// handshake, starting at in_start and walking upward with wrap-around.
module select_scanner #(
  parameter int WIDTH = 7,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_start,
  input  logic [SW-1:0]    in_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_oob,
  output logic             out_last
);
  localparam int NSEL = 1 << SW;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic             run;

  // Every reachable index gets a slot; slots past WIDTH read as 0 and flag oob.
  logic [NSEL-1:0]  bit_vec, oob_vec;

  for (genvar i = 0; i < NSEL; i++) begin : g_sel
    if (i < WIDTH) begin : g_in
      assign bit_vec[i] = data_q[i];
      assign oob_vec[i] = 1'b0;
    end else begin : g_out
      assign bit_vec[i] = 1'b0;
      assign oob_vec[i] = 1'b1;
    end
  end

  assign run       = (state_q == RUN);
  // rst is folded in so in_ready reads 0 throughout reset yet is 1 as soon as it drops.
  assign in_ready  = !run && !rst;
  assign out_valid = run;
  assign out_bit   = run & bit_vec[idx_q];
  assign out_oob   = oob_vec[idx_q];
  assign out_last  = run && (rem_q == '0);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          data_d  = in_data;
          idx_d   = in_start;
          rem_d   = in_len;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (rem_q == '0) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
            rem_d = rem_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end
endmodule

// File: tb/tb_select_scanner.sv
// Directed bench for select_scanner: a queue-of-beats model checked every
// cycle, plus literal beat sequences for each scenario.
module tb_select_scanner;
  localparam int WIDTH = 7;
  localparam int SW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [SW-1:0]    in_start = '0;
  logic [SW-1:0]    in_len = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_bit, out_oob, out_last;

  int errors = 0;
  int checks = 0;
  int stalls = 0;

  // Model: pending beats {bit, oob, last}; the front one is what must be on the outputs.
  logic [2:0] mq[$];
  logic [2:0] blog[$];

  select_scanner #(.WIDTH(WIDTH), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_start(in_start), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_oob(out_oob), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk_int(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else if (mq.size() > 0) begin
      if (out_ready) void'(mq.pop_front());
    end else if (in_valid) begin
      for (int k = 0; k <= int'(in_len); k++) begin
        int   ix;
        logic b;
        ix = (int'(in_start) + k) % (1 << SW);
        b  = (ix < WIDTH) ? in_data[ix] : 1'b0;
        mq.push_back({b, ix >= WIDTH, k == int'(in_len)});
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] f;
    logic       ev;
    ev = (mq.size() > 0);
    f  = ev ? mq[0] : 3'b000;
    chk("in_ready", in_ready, !ev && !rst);
    chk("out_valid", out_valid, ev);
    chk("out_last", out_last, f[0]);
    if (ev || rst) begin
      chk("out_bit", out_bit, f[2]);
      chk("out_oob", out_oob, f[1]);
    end
    if (out_valid && !out_ready) stalls++;
    if (out_valid && out_ready) blog.push_back({out_bit, out_oob, out_last});
  end

  task automatic wait_ready(input string n);
    int c = 0;
    while (!in_ready && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (!in_ready) chk(n, 1'b0, 1'b1);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [SW-1:0] s, input logic [SW-1:0] l);
    wait_ready("timeout_ready");
    in_data  = d;
    in_start = s;
    in_len   = l;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Beat i of the log is compared against bit i of each literal vector.
  task automatic check_log(input string n, input int cnt, input logic [7:0] bits,
                           input logic [7:0] oob, input logic [7:0] last);
    chk_int({n, "_count"}, blog.size(), cnt);
    for (int i = 0; i < cnt && i < blog.size(); i++) begin
      chk({n, "_bit"},  blog[i][2], bits[i]);
      chk({n, "_oob"},  blog[i][1], oob[i]);
      chk({n, "_last"}, blog[i][0], last[i]);
    end
    blog.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_reset", in_ready, 1'b1);
    chk("valid_after_reset", out_valid, 1'b0);

    // Full scan
    blog.delete();
    send(7'b1011001, 3'd0, 3'd6);
    wait_ready("timeout_full");
    check_log("full", 7, 8'b0101_1001, 8'b0, 8'b0100_0000);

    // Wrap through index 7 (out of range) back to 0
    send(7'b1011001, 3'd5, 3'd3);
    wait_ready("timeout_wrap");
    check_log("wrap", 4, 8'b0000_1010, 8'b0000_0100, 8'b0000_1000);

    // Backpressure: first beat held for 4 cycles
    out_ready = 1'b0;
    stalls = 0;
    send(7'b1011001, 3'd2, 3'd1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_ready("timeout_bp");
    chk_int("bp_stalls", stalls, 3);
    check_log("bp", 2, 8'b0000_0010, 8'b0, 8'b0000_0010);

    // Second request during RUN must be ignored
    send(7'b1011001, 3'd0, 3'd6);
    in_data  = 7'h7F;
    in_start = 3'd3;
    in_len   = 3'd1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_ready("timeout_ign");
    check_log("ignored", 7, 8'b0101_1001, 8'b0, 8'b0100_0000);

    // Reset during the 2nd bit of a full scan
    send(7'b1011001, 3'd0, 3'd6);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_last", out_last, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("midrst_ready_after", in_ready, 1'b1);
    check_log("midrst_pre", 1, 8'b1, 8'b0, 8'b0);
    send(7'b1011001, 3'd0, 3'd2);
    wait_ready("timeout_midrst");
    check_log("midrst_new", 3, 8'b0000_0001, 8'b0, 8'b0000_0100);

    // Single bit
    send(7'b1000000, 3'd6, 3'd0);
    chk("single_valid", out_valid, 1'b1);
    chk("single_last", out_last, 1'b1);
    chk("single_bit", out_bit, 1'b1);
    @(posedge clk); #1;
    chk("single_ready_next", in_ready, 1'b1);
    chk("single_done", out_valid, 1'b0);
    check_log("single", 1, 8'b1, 8'b0, 8'b1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
